// File: rtl/fix2float_pkg.sv
// Shared definitions for the fixed-to-float converter: FSM states and IEEE-754 single constants.
package fix2float_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        NORM = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int          FP_BIAS  = 127;
    localparam int          FP_EXP_W = 8;
    localparam int          FP_MAN_W = 23;
    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

    function automatic logic [31:0] fp_word(input logic s, input logic [FP_EXP_W-1:0] e,
                                            input logic [FP_MAN_W-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/fix2float_conv_if.sv
// Begin/ACK handshake bundle between the sample source and the converter.
interface fix2float_conv_if #(
    parameter int W = 32,
    parameter int P = 32
);
    logic         Begin_FSM_FF;
    logic [W-1:0] DATA_FIXED;
    logic         ACK_FF;
    logic [P-1:0] RESULT;

    modport master (output Begin_FSM_FF, DATA_FIXED, input ACK_FF, RESULT);
    modport slave  (input Begin_FSM_FF, DATA_FIXED, output ACK_FF, RESULT);
endinterface

// File: rtl/fix2float_pack.sv
// Combinational float assembly from a normalised magnitude; FIX2FLOAT_ROUND_NEAREST_EN
// selects round-to-nearest-even instead of truncation.
module fix2float_pack
    import fix2float_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int KW   = 5
) (
    input  logic          sign,
    input  logic          zero,
    input  logic [W-1:0]  mag,
    input  logic [KW-1:0] k,
    output logic [31:0]   word
);
    localparam int EXP_OFF = FP_BIAS + W - 1 - FRAC;

    logic [9:0]          exp_base;
    logic [9:0]          exp_fin;
    logic [FP_MAN_W-1:0] man_trunc;
    logic [FP_MAN_W-1:0] man_fin;
    logic                guard;
    logic                sticky;
    logic                unused_bits;

    assign exp_base  = 10'(EXP_OFF) - 10'(k);
    assign man_trunc = mag[W-2 -: FP_MAN_W];
    assign guard     = mag[W-25];

    generate
        if (W >= 26) begin : g_sticky
            assign sticky = |mag[W-26:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

`ifdef FIX2FLOAT_ROUND_NEAREST_EN
    logic round_up;
    logic carry;

    // A carry out of the mantissa leaves it all-zero, which is exactly the
    // normalised mantissa of the next binade.
    assign round_up         = guard & (sticky | man_trunc[0]);
    assign {carry, man_fin} = {1'b0, man_trunc} + (FP_MAN_W + 1)'(round_up);
    assign exp_fin          = exp_base + 10'(carry);
    assign unused_bits      = ^{mag[W-1], exp_fin[9:8]};
`else
    assign man_fin     = man_trunc;
    assign exp_fin     = exp_base;
    assign unused_bits = ^{mag[W-1], exp_fin[9:8], guard, sticky};
`endif

    assign word = zero ? FP_ZERO : fp_word(sign, exp_fin[FP_EXP_W-1:0], man_fin);

endmodule

// File: rtl/fix2float_conv.sv
// Signed fixed-point to IEEE-754 single converter; iterative normalisation, one shift per clock.
// Optional rounding: define FIX2FLOAT_ROUND_NEAREST_EN (handled in fix2float_pack).
module fix2float_conv
    import fix2float_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int P    = 32
) (
    input  logic CLK,
    input  logic RST_N,
    fix2float_conv_if.slave bus
);
    localparam int KW = $clog2(W);

    state_t        state_q, state_d;
    logic [W-1:0]  data_q;
    logic [W-1:0]  mag_q;
    logic [W-1:0]  mag_load;
    logic [KW-1:0] k_q;
    logic          sign_q;
    logic          zero_q;
    logic          ack_q;
    logic [P-1:0]  result_q;
    logic [31:0]   pack_word;

    // Two's-complement negate wraps -2^(W-1) onto itself, which read unsigned is 2^(W-1).
    assign mag_load = data_q[W-1] ? (~data_q + 1'b1) : data_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Begin_FSM_FF) state_d = LOAD;
            LOAD:    state_d = (data_q == '0) ? PACK : NORM;
            NORM:    if (mag_q[W-1]) state_d = PACK;
            PACK:    state_d = DONE;
            DONE:    if (bus.Begin_FSM_FF) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q   <= '0;
            mag_q    <= '0;
            k_q      <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ack_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.Begin_FSM_FF) data_q <= bus.DATA_FIXED;
                LOAD: begin
                    sign_q <= data_q[W-1];
                    mag_q  <= mag_load;
                    k_q    <= '0;
                    zero_q <= (data_q == '0);
                end
                NORM: if (!mag_q[W-1]) begin
                    mag_q <= mag_q << 1;
                    k_q   <= k_q + 1'b1;
                end
                PACK: begin
                    result_q <= P'(pack_word);
                    ack_q    <= 1'b1;
                end
                DONE: if (bus.Begin_FSM_FF) begin
                    ack_q  <= 1'b0;
                    data_q <= bus.DATA_FIXED;
                end
                default: ;
            endcase
        end
    end

    fix2float_pack #(.W(W), .FRAC(FRAC), .KW(KW)) u_pack (
        .sign (sign_q),
        .zero (zero_q),
        .mag  (mag_q),
        .k    (k_q),
        .word (pack_word)
    );

    assign bus.ACK_FF = ack_q;
    assign bus.RESULT = result_q;

endmodule

// File: tb/tb_fix2float_conv.sv
// Directed plus randomized checks of fix2float_conv (W=32, FRAC=16) against an arithmetic reference.
module tb_fix2float_conv;
    import fix2float_pkg::*;

    localparam int W    = 32;
    localparam int FRAC = 16;

    logic CLK = 1'b0;
    logic RST_N;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    fix2float_conv_if #(.W(W), .P(32)) bus ();

    fix2float_conv #(.W(W), .FRAC(FRAC), .P(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int msb_pos(input longint unsigned m);
        int p = -1;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        return p;
    endfunction

    function automatic longint unsigned magnitude(input logic [31:0] d);
        longint v = longint'($signed(d));
        return longint'(v < 0 ? -v : v);
    endfunction

    // Value-level reference: exponent from the MSB position, fraction from the bits below it.
    function automatic logic [31:0] ref_word(input logic [31:0] d);
        longint unsigned m, man;
        int p, e;
        if (d == 32'd0) return 32'd0;
        m   = magnitude(d);
        p   = msb_pos(m);
        e   = FP_BIAS + p - FRAC;
        man = m - (64'd1 << p);
        if (p >= 23) begin
`ifdef FIX2FLOAT_ROUND_NEAREST_EN
            longint unsigned low, half;
            low = man & ((64'd1 << (p - 23)) - 1);
            man = man >> (p - 23);
            if (p > 23) begin
                half = 64'd1 << (p - 24);
                if (low > half || (low == half && man[0])) man++;
            end
            if (man == (64'd1 << 23)) begin
                man = 0;
                e++;
            end
`else
            man = man >> (p - 23);
`endif
        end else begin
            man = man << (23 - p);
        end
        return {d[31], e[7:0], man[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] d);
        if (d == 32'd0) return 3;
        return (31 - msb_pos(magnitude(d))) + 4;
    endfunction

    // Begin edge counts as edge 1; a second Begin is pulsed after edge pulse_at (0 = none).
    task automatic convert(input logic [31:0] d, input int pulse_at, input string tag);
        logic [31:0] prev;
        int          n;
        bit          got;
        @(negedge CLK);
        bus.Begin_FSM_FF = 1'b1;
        bus.DATA_FIXED   = d;
        prev             = bus.RESULT;
        @(posedge CLK);
        n = 1;
        @(negedge CLK);
        bus.Begin_FSM_FF = 1'b0;
        bus.DATA_FIXED   = $urandom;
        check({tag, " ack_clear"}, 64'(bus.ACK_FF), 64'd0);
        check({tag, " result_hold"}, 64'(bus.RESULT), 64'(prev));
        got = 1'b0;
        while (!got && n < 80) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            bus.Begin_FSM_FF = (n == pulse_at);
            if (n == pulse_at) bus.DATA_FIXED = $urandom;
            if (bus.ACK_FF) got = 1'b1;
        end
        bus.Begin_FSM_FF = 1'b0;
        check({tag, " latency"}, 64'(got ? n : -1), 64'(ref_lat(d)));
        check({tag, " result"}, 64'(bus.RESULT), 64'(ref_word(d)));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] held;

        RST_N            = 1'b0;
        bus.Begin_FSM_FF = 1'b0;
        bus.DATA_FIXED   = '0;
        #1;
        check("reset ack", 64'(bus.ACK_FF), 64'd0);
        check("reset result", 64'(bus.RESULT), 64'd0);
        check("reset state", 64'(dut.state_q), 64'(IDLE));
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        convert(32'h0001_0000, 0, "one");
        check("one const", 64'(bus.RESULT), 64'h3F80_0000);
        convert(32'hFFFF_0000, 0, "minus_one");
        check("minus_one const", 64'(bus.RESULT), 64'hBF80_0000);
        convert(32'h0000_0000, 0, "zero");
        check("zero const", 64'(bus.RESULT), 64'h0000_0000);
        convert(32'h8000_0000, 0, "most_neg");
        check("most_neg const", 64'(bus.RESULT), 64'hC700_0000);
        convert(32'h7FFF_FFFF, 0, "max_pos");
`ifdef FIX2FLOAT_ROUND_NEAREST_EN
        check("max_pos const", 64'(bus.RESULT), 64'h4700_0000);
`else
        check("max_pos const", 64'(bus.RESULT), 64'h46FF_FFFF);
`endif
        convert(32'h0000_0001, 0, "lsb");
        convert(32'hFFFF_FFFF, 0, "minus_lsb");

        // Begin pulses while busy must neither restart nor queue a conversion.
        convert(32'h0001_0000, 5, "ignore_norm");
        check("ignore_norm const", 64'(bus.RESULT), 64'h3F80_0000);
        convert(32'h0000_0300, 2, "ignore_load");

        held = bus.RESULT;
        repeat (4) @(negedge CLK);
        check("done ack hold", 64'(bus.ACK_FF), 64'd1);
        check("done result hold", 64'(bus.RESULT), 64'(held));

        convert(32'h0002_0000, 0, "two");
        check("two const", 64'(bus.RESULT), 64'h4000_0000);

        for (int i = 0; i < 40; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) d = -d;
            convert(d, 0, $sformatf("rand%0d", i));
        end

        // Reset in the middle of normalisation.
        @(negedge CLK);
        bus.Begin_FSM_FF = 1'b1;
        bus.DATA_FIXED   = 32'h0001_0000;
        @(negedge CLK);
        bus.Begin_FSM_FF = 1'b0;
        repeat (4) @(negedge CLK);
        check("pre_abort state", 64'(dut.state_q), 64'(NORM));
        RST_N = 1'b0;
        #1;
        check("abort ack", 64'(bus.ACK_FF), 64'd0);
        check("abort result", 64'(bus.RESULT), 64'd0);
        check("abort state", 64'(dut.state_q), 64'(IDLE));
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (25) @(negedge CLK);
        check("abort no_resume", 64'(bus.ACK_FF), 64'd0);
        convert(32'h0001_0000, 0, "after_abort");
        check("after_abort const", 64'(bus.RESULT), 64'h3F80_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
